mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8: consecutive imem losses before imem is forced a grant.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have client-I ports: imem_read in 1; imem_address in 16 (lc3b_word); imem_rdata out 16; imem_resp out 1.
REQ-005 SHALL have client-D ports: dmem_read in 1; dmem_write in 1; dmem_address in 16; dmem_wdata in 16; dmem_byte_enable in 2 (lc3b_mem_wmask); dmem_rdata out 16; dmem_resp out 1.
REQ-006 SHALL have memory ports: pmem_read out 1; pmem_write out 1; pmem_address out 16; pmem_wdata out 16; pmem_wmask out 2; pmem_rdata in 16; pmem_resp in 1.
REQ-007 SHALL have perf ports: perf_igrant out 16; perf_dgrant out 16; perf_conflict out 16.

Function
REQ-008 SHALL implement an FSM with states IDLE, SERVE_I, SERVE_D, DONE.
REQ-009 IDLE SHALL grant, in order: imem if imem_read and starve_cnt >= MAX_WAIT; else dmem if dmem_read|dmem_write; else imem if imem_read; else stay.
REQ-010 On grant, SHALL latch address/wdata/mask/direction into a request register and enter SERVE_I or SERVE_D next cycle.
REQ-011 In SERVE_x, SHALL drive pmem_* only from the latched register; pmem_read/pmem_write high continuously until pmem_resp.
REQ-012 On pmem_resp in SERVE_x, SHALL capture pmem_rdata, drop pmem_read/pmem_write next cycle, and enter DONE.
REQ-013 In DONE, SHALL assert imem_resp or dmem_resp (matching the served client) for exactly one cycle with captured data on the matching rdata, then return to IDLE.
REQ-014 Latency: request seen in IDLE at cycle 0 -> pmem request at cycle 1 -> pmem_resp at cycle k -> client resp at cycle k+1; minimum 3 cycles.
REQ-015 imem_rdata/dmem_rdata SHALL hold the last captured value between transactions.
REQ-016 starve_cnt (4-bit, saturating) SHALL increment on each dmem grant while imem_read is high; clear on imem grant.
REQ-017 dmem_read and dmem_write both high SHALL be served as a write; the read is dropped.
REQ-018 A client dropping its request after grant SHALL NOT abort the transaction; the resp pulse is still issued (flush tolerance).
REQ-019 Back-to-back: a request still high in the IDLE cycle after DONE SHALL be arbitrated normally; no request is re-served from stale latched state.
REQ-020 pmem_resp outside SERVE_x SHALL be ignored.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, pmem_read=pmem_write=0, imem_resp=dmem_resp=0, starve_cnt=0, request register, rdata registers and perf counters to 0.
REQ-022 Reset mid-transaction SHALL abandon it with no resp pulse; first grant is possible in the first cycle after rst_n rises.

Configuration
REQ-023 Macro MEM_ARB_PERF_EN defined: perf_igrant/perf_dgrant SHALL count grants, perf_conflict SHALL count IDLE cycles with both clients requesting, all 16-bit saturating at 16'hFFFF.
REQ-024 Macro MEM_ARB_PERF_EN undefined: perf ports SHALL remain present and be tied to 0; no counter logic is synthesized.

Structure
REQ-025 lc3b_word and lc3b_mem_wmask SHALL come from lc3b_types; MEM_ARB_MAX_WAIT default constant and mem_arb_state_t enum SHALL be added to lc3b_types.
REQ-026 Perf counters SHALL live in one sub-module mem_arb_perf, instantiated only under MEM_ARB_PERF_EN.

Verification
REQ-027 imem_read, addr 16'h0010, pmem_resp after 2 cycles, rdata 16'h1234 -> pmem_read cycles 1-3, imem_resp one cycle at cycle 4, imem_rdata=16'h1234.
REQ-028 imem_read and dmem_write (addr 16'h8000, wdata 16'hBEEF, mask 2'b01) same cycle -> dmem served first with pmem_wmask=2'b01; imem served next.
REQ-029 imem_read held with dmem requesting continuously, MAX_WAIT=8 -> imem granted on the 9th arbitration; starve_cnt then 0.
REQ-030 rst_n pulsed low in SERVE_D with pmem_read high -> pmem_read 0 asynchronously, no dmem_resp, state IDLE.
REQ-031 imem_read drops one cycle after grant -> pmem transaction completes; imem_resp still pulses once.
REQ-032 With MEM_ARB_PERF_EN, 3 conflicting IDLE cycles -> perf_conflict=3; without the macro -> all perf ports 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types plus the arbiter's default starvation limit and state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam int MEM_ARB_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } mem_arb_state_t;

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating 16-bit grant and conflict counters for the memory arbiter.
module mem_arb_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        igrant,
  input  logic        dgrant,
  input  logic        conflict,
  output logic [15:0] perf_igrant,
  output logic [15:0] perf_dgrant,
  output logic [15:0] perf_conflict
);

  // Each counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_igrant   <= 16'd0;
      perf_dgrant   <= 16'd0;
      perf_conflict <= 16'd0;
    end else begin
      if (igrant && (perf_igrant != 16'hFFFF))
        perf_igrant <= perf_igrant + 16'd1;
      if (dgrant && (perf_dgrant != 16'hFFFF))
        perf_dgrant <= perf_dgrant + 16'd1;
      if (conflict && (perf_conflict != 16'hFFFF))
        perf_conflict <= perf_conflict + 16'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (instruction/data) arbiter onto one physical memory port with starvation guard.
// Define MEM_ARB_PERF_EN to build the grant/conflict performance counters.
import lc3b_types::*;

module mem_arbiter #(
  parameter int MAX_WAIT = MEM_ARB_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          imem_read,
  input  lc3b_word      imem_address,
  output lc3b_word      imem_rdata,
  output logic          imem_resp,
  input  logic          dmem_read,
  input  logic          dmem_write,
  input  lc3b_word      dmem_address,
  input  lc3b_word      dmem_wdata,
  input  lc3b_mem_wmask dmem_byte_enable,
  output lc3b_word      dmem_rdata,
  output logic          dmem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_wmask,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp,
  output logic [15:0]   perf_igrant,
  output logic [15:0]   perf_dgrant,
  output logic [15:0]   perf_conflict
);

  mem_arb_state_t state;
  logic [3:0]     starve_cnt;
  lc3b_word       req_addr;
  lc3b_word       req_wdata;
  lc3b_mem_wmask  req_mask;
  logic           req_write;
  logic           req_dmem;

  logic dmem_req;
  logic starved;
  logic grant_i;
  logic grant_d;
  logic serving;

  // A starved imem overrides the normal data-first priority.
  assign dmem_req = dmem_read | dmem_write;
  assign starved  = imem_read && ({28'd0, starve_cnt} >= 32'(MAX_WAIT));
  assign grant_i  = (state == IDLE) && (starved || (imem_read && !dmem_req));
  assign grant_d  = (state == IDLE) && dmem_req && !starved;
  assign serving  = (state == SERVE_I) || (state == SERVE_D);

  assign pmem_read    = serving && !req_write;
  assign pmem_write   = serving && req_write;
  assign pmem_address = req_addr;
  assign pmem_wdata   = req_wdata;
  assign pmem_wmask   = req_mask;

  assign imem_resp = (state == DONE) && !req_dmem;
  assign dmem_resp = (state == DONE) && req_dmem;

  // Memory is only ever driven from the request latched at grant, so clients may drop early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_mask   <= '0;
      req_write  <= 1'b0;
      req_dmem   <= 1'b0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= SERVE_D;
            req_addr  <= dmem_address;
            req_wdata <= dmem_wdata;
            req_mask  <= dmem_byte_enable;
            req_write <= dmem_write;
            req_dmem  <= 1'b1;
            if (imem_read && (starve_cnt != 4'hF))
              starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_i) begin
            state      <= SERVE_I;
            req_addr   <= imem_address;
            req_wdata  <= '0;
            req_mask   <= '0;
            req_write  <= 1'b0;
            req_dmem   <= 1'b0;
            starve_cnt <= 4'd0;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            imem_rdata <= pmem_rdata;
            state      <= DONE;
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            dmem_rdata <= pmem_rdata;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic conflict;

  assign conflict = (state == IDLE) && imem_read && dmem_req;

  mem_arb_perf u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .igrant        (grant_i),
    .dgrant        (grant_d),
    .conflict      (conflict),
    .perf_igrant   (perf_igrant),
    .perf_dgrant   (perf_dgrant),
    .perf_conflict (perf_conflict)
  );
`else
  assign perf_igrant   = 16'd0;
  assign perf_dgrant   = 16'd0;
  assign perf_conflict = 16'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 8;
`ifdef MEM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;
  logic [15:0] perf_igrant;
  logic [15:0] perf_dgrant;
  logic [15:0] perf_conflict;

  int vectors = 0;
  int miscompares = 0;

  // memory responder state
  int          cur_lat;
  int          mem_wait;
  logic [15:0] next_rdata;
  bit          spurious;

  // reference model: phase 0 free, 1 memory busy, 2 client response cycle
  int          m_phase;
  bit          m_cli_d;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [1:0]  m_mask;
  bit          m_write;
  int          m_starve;
  logic [15:0] m_irdata;
  logic [15:0] m_drdata;
  int          m_ig;
  int          m_dg;
  int          m_cf;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_read        (imem_read),
    .imem_address     (imem_address),
    .imem_rdata       (imem_rdata),
    .imem_resp        (imem_resp),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_wmask       (pmem_wmask),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp),
    .perf_igrant      (perf_igrant),
    .perf_dgrant      (perf_dgrant),
    .perf_conflict    (perf_conflict)
  );

  task automatic model_reset();
    m_phase  = 0;
    m_cli_d  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_mask   = '0;
    m_write  = 1'b0;
    m_starve = 0;
    m_irdata = '0;
    m_drdata = '0;
    m_ig     = 0;
    m_dg     = 0;
    m_cf     = 0;
    pmem_resp = 1'b0;
    mem_wait  = 0;
    spurious  = 1'b0;
  endtask

  // Advance one clock: memory responds at the falling edge, the model steps, outputs are checked after the edge.
  task automatic run_cycle();
    bit dreq;
    bit starved;
    bit exp_pr;
    bit exp_pw;
    logic [15:0] exp_ig;
    logic [15:0] exp_dg;
    logic [15:0] exp_cf;
    @(negedge clk);
    if (pmem_resp) begin
      pmem_resp = 1'b0;
    end else if (pmem_read || pmem_write) begin
      if (mem_wait >= cur_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = next_rdata;
        mem_wait   = 0;
        cur_lat    = $urandom_range(0, 3);
        next_rdata = 16'($urandom);
      end else begin
        mem_wait++;
      end
    end else if (spurious) begin
      pmem_resp  = 1'b1;
      pmem_rdata = 16'hDEAD;
    end
    spurious = 1'b0;

    dreq    = dmem_read | dmem_write;
    starved = imem_read && (m_starve >= MAX_WAIT);
    case (m_phase)
      0: begin
        if (imem_read && dreq && m_cf < 65535) m_cf++;
        if (dreq && !starved) begin
          m_phase = 1; m_cli_d = 1'b1; m_addr = dmem_address; m_wdata = dmem_wdata;
          m_mask = dmem_byte_enable; m_write = dmem_write;
          if (m_dg < 65535) m_dg++;
          if (imem_read && m_starve < 15) m_starve++;
        end else if (imem_read) begin
          m_phase = 1; m_cli_d = 1'b0; m_addr = imem_address; m_write = 1'b0;
          if (m_ig < 65535) m_ig++;
          m_starve = 0;
        end
      end
      1: begin
        if (pmem_resp) begin
          m_phase = 2;
          if (m_cli_d) m_drdata = pmem_rdata;
          else m_irdata = pmem_rdata;
        end
      end
      default: m_phase = 0;
    endcase

    @(posedge clk);
    #1;
    exp_pr = (m_phase == 1) && !m_write;
    exp_pw = (m_phase == 1) && m_write;
    exp_ig = PERF ? 16'(m_ig) : 16'd0;
    exp_dg = PERF ? 16'(m_dg) : 16'd0;
    exp_cf = PERF ? 16'(m_cf) : 16'd0;
    vectors++;
    if (pmem_read !== exp_pr) begin
      miscompares++; $display("[TB] FAIL pmem_read: got %b expected %b at %0t", pmem_read, exp_pr, $time);
    end
    vectors++;
    if (pmem_write !== exp_pw) begin
      miscompares++; $display("[TB] FAIL pmem_write: got %b expected %b at %0t", pmem_write, exp_pw, $time);
    end
    if (m_phase == 1) begin
      vectors++;
      if (pmem_address !== m_addr) begin
        miscompares++; $display("[TB] FAIL pmem_address: got %h expected %h at %0t", pmem_address, m_addr, $time);
      end
    end
    if (exp_pw) begin
      vectors++;
      if (pmem_wdata !== m_wdata || pmem_wmask !== m_mask) begin
        miscompares++;
        $display("[TB] FAIL pmem_wdata/wmask: got %h/%b expected %h/%b at %0t", pmem_wdata, pmem_wmask, m_wdata, m_mask, $time);
      end
    end
    vectors++;
    if (imem_resp !== (m_phase == 2 && !m_cli_d) || dmem_resp !== (m_phase == 2 && m_cli_d)) begin
      miscompares++;
      $display("[TB] FAIL resp: got i=%b d=%b expected i=%b d=%b at %0t", imem_resp, dmem_resp,
               (m_phase == 2 && !m_cli_d), (m_phase == 2 && m_cli_d), $time);
    end
    vectors++;
    if (imem_rdata !== m_irdata || dmem_rdata !== m_drdata) begin
      miscompares++;
      $display("[TB] FAIL rdata: got i=%h d=%h expected i=%h d=%h at %0t", imem_rdata, dmem_rdata, m_irdata, m_drdata, $time);
    end
    vectors++;
    if (perf_igrant !== exp_ig || perf_dgrant !== exp_dg || perf_conflict !== exp_cf) begin
      miscompares++;
      $display("[TB] FAIL perf: got %0d/%0d/%0d expected %0d/%0d/%0d at %0t", perf_igrant, perf_dgrant, perf_conflict,
               exp_ig, exp_dg, exp_cf, $time);
    end
  endtask

  task automatic clear_inputs();
    imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    imem_address = '0; dmem_address = '0; dmem_wdata = '0; dmem_byte_enable = '0;
    pmem_rdata = '0;
    model_reset();
    #3;
    vectors++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || imem_resp !== 1'b0 || dmem_resp !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_ctrl: got r=%b w=%b ir=%b dr=%b expected all 0", pmem_read, pmem_write, imem_resp, dmem_resp);
    end
    vectors++;
    if (imem_rdata !== 16'h0 || dmem_rdata !== 16'h0 || pmem_address !== 16'h0) begin
      miscompares++; $display("[TB] FAIL reset_data: got %h %h %h expected 0", imem_rdata, dmem_rdata, pmem_address);
    end
    vectors++;
    if (perf_igrant !== 16'h0 || perf_dgrant !== 16'h0 || perf_conflict !== 16'h0) begin
      miscompares++; $display("[TB] FAIL reset_perf: got %h %h %h expected 0", perf_igrant, perf_dgrant, perf_conflict);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle();
  endtask

  task automatic test_single_read();
    clear_inputs();
    imem_read = 1'b1; imem_address = 16'h0010;
    cur_lat = 2; mem_wait = 0; next_rdata = 16'h1234;
    for (int c = 1; c <= 5; c++) begin
      run_cycle();
      if (c == 1) imem_read = 1'b0;
      vectors++;
      if (pmem_read !== (c <= 3)) begin
        miscompares++; $display("[TB] FAIL single_pmem_read c%0d: got %b expected %b", c, pmem_read, (c <= 3));
      end
      vectors++;
      if (imem_resp !== (c == 4)) begin
        miscompares++; $display("[TB] FAIL single_imem_resp c%0d: got %b expected %b", c, imem_resp, (c == 4));
      end
      if (c == 4) begin
        vectors++;
        if (imem_rdata !== 16'h1234) begin
          miscompares++; $display("[TB] FAIL single_rdata: got %h expected 1234", imem_rdata);
        end
      end
    end
  endtask

  task automatic test_conflict();
    int d_resp_at;
    int i_grant_at;
    clear_inputs();
    imem_read = 1'b1; imem_address = 16'h0100;
    dmem_write = 1'b1; dmem_address = 16'h8000; dmem_wdata = 16'hBEEF; dmem_byte_enable = 2'b01;
    run_cycle();
    vectors++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h8000 || pmem_wmask !== 2'b01) begin
      miscompares++; $display("[TB] FAIL conflict_dfirst: got w=%b r=%b a=%h m=%b expected w=1 r=0 a=8000 m=01",
                              pmem_write, pmem_read, pmem_address, pmem_wmask);
    end
    dmem_write = 1'b0;
    d_resp_at = -1; i_grant_at = -1;
    for (int c = 0; c < 20; c++) begin
      run_cycle();
      if (dmem_resp && d_resp_at < 0) d_resp_at = c;
      if (pmem_read && i_grant_at < 0) begin
        i_grant_at = c;
        vectors++;
        if (pmem_address !== 16'h0100) begin
          miscompares++; $display("[TB] FAIL conflict_iaddr: got %h expected 0100", pmem_address);
        end
      end
      if (imem_resp) begin
        imem_read = 1'b0;
        break;
      end
    end
    vectors++;
    if (d_resp_at < 0 || i_grant_at <= d_resp_at) begin
      miscompares++; $display("[TB] FAIL conflict_order: got dresp@%0d igrant@%0d expected dresp before igrant", d_resp_at, i_grant_at);
    end
    clear_inputs();
    for (int c = 0; c < 4; c++) run_cycle();
  endtask

  task automatic test_starvation();
    int n;
    int first_i;
    bit prev;
    bit active;
    logic [15:0] tenth_addr;
    clear_inputs();
    imem_read = 1'b1; imem_address = 16'h1111;
    dmem_read = 1'b1; dmem_address = 16'h2222;
    n = 0; first_i = 0; prev = 1'b0; tenth_addr = '0;
    for (int c = 0; c < 150 && n < 10; c++) begin
      run_cycle();
      active = pmem_read | pmem_write;
      if (active && !prev) begin
        n++;
        if (pmem_address == 16'h1111 && first_i == 0) first_i = n;
        if (n == 10) tenth_addr = pmem_address;
      end
      prev = active;
    end
    clear_inputs();
    vectors++;
    if (first_i !== 9) begin
      miscompares++; $display("[TB] FAIL starve_igrant: got imem on arbitration %0d expected 9", first_i);
    end
    vectors++;
    if (tenth_addr !== 16'h2222) begin
      miscompares++; $display("[TB] FAIL starve_cleared: got 10th grant addr %h expected 2222", tenth_addr);
    end
    for (int c = 0; c < 8; c++) run_cycle();
  endtask

  task automatic test_flush();
    int pulses;
    clear_inputs();
    imem_read = 1'b1; imem_address = 16'h3030;
    next_rdata = 16'h5A5A;
    run_cycle();
    vectors++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3030) begin
      miscompares++; $display("[TB] FAIL flush_grant: got r=%b a=%h expected r=1 a=3030", pmem_read, pmem_address);
    end
    imem_read = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      if (imem_resp) pulses++;
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++; $display("[TB] FAIL flush_resp_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_spurious();
    clear_inputs();
    spurious = 1'b1;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      vectors++;
      if (imem_resp !== 1'b0 || dmem_resp !== 1'b0 || pmem_read !== 1'b0 || imem_rdata !== 16'h5A5A) begin
        miscompares++; $display("[TB] FAIL spurious_resp: got ir=%b dr=%b r=%b irdata=%h expected 0 0 0 5a5a",
                                imem_resp, dmem_resp, pmem_read, imem_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    dmem_read = 1'b1; dmem_address = 16'h4444;
    cur_lat = 6; mem_wait = 0;
    run_cycle();
    vectors++;
    if (pmem_read !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rstmid_pre: got pmem_read=%b expected 1", pmem_read);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pmem_read !== 1'b0 || dmem_resp !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rstmid_async: got r=%b dr=%b expected 0 0", pmem_read, dmem_resp);
    end
    model_reset();
    @(posedge clk); #1;
    vectors++;
    if (dmem_resp !== 1'b0 || dmem_rdata !== 16'h0) begin
      miscompares++; $display("[TB] FAIL rstmid_held: got dr=%b drdata=%h expected 0 0", dmem_resp, dmem_rdata);
    end
    rst_n = 1'b1;
    cur_lat = 1;
    run_cycle();
    vectors++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h4444) begin
      miscompares++; $display("[TB] FAIL rstmid_regrant: got r=%b a=%h expected 1 4444", pmem_read, pmem_address);
    end
    clear_inputs();
    for (int c = 0; c < 8; c++) run_cycle();
  endtask

  task automatic test_perf();
    int n;
    bit prev;
    bit active;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_read = 1'b1; imem_address = 16'h0A0A;
    dmem_read = 1'b1; dmem_address = 16'h0B0B;
    n = 0; prev = 1'b0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      run_cycle();
      active = pmem_read | pmem_write;
      if (active && !prev) n++;
      prev = active;
    end
    clear_inputs();
    for (int c = 0; c < 8; c++) run_cycle();
    vectors++;
    if (perf_conflict !== (PERF ? 16'd3 : 16'd0) || perf_dgrant !== (PERF ? 16'd3 : 16'd0)) begin
      miscompares++; $display("[TB] FAIL perf_conflict: got conflict=%0d dgrant=%0d expected %0d %0d",
                              perf_conflict, perf_dgrant, (PERF ? 3 : 0), (PERF ? 3 : 0));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      imem_read        = ($urandom_range(0, 9) < 7);
      dmem_read        = ($urandom_range(0, 9) < 4);
      dmem_write       = ($urandom_range(0, 9) < 3);
      imem_address     = 16'($urandom);
      dmem_address     = 16'($urandom);
      dmem_wdata       = 16'($urandom);
      dmem_byte_enable = 2'($urandom_range(0, 3));
      run_cycle();
    end
    clear_inputs();
    for (int c = 0; c < 8; c++) run_cycle();
  endtask

  initial begin
    cur_lat = 1;
    next_rdata = 16'($urandom);
    test_reset();
    test_single_read();
    test_conflict();
    test_starvation();
    test_flush();
    test_spurious();
    test_reset_mid();
    test_perf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
